// File: rtl/nn_pkg.sv
// nn_pkg
// Shared types for the CNN training scheduler slice.
//   q8_8_t        signed Q8.8 scalar
//   kernel_t      3x3 convolution kernel
//   fc_w_t        four fully-connected weights
//   feature_t     4x4 input feature map
//   sched_state_e scheduler FSM states
//   abs_diff()    |a - b| of two Q8.8 values, computed in 17 bits so it never wraps
package nn_pkg;

    typedef logic signed [15:0] q8_8_t;
    typedef q8_8_t [2:0][2:0] kernel_t;
    typedef q8_8_t [3:0] fc_w_t;
    typedef q8_8_t [3:0][3:0] feature_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FWD,
        ST_TRAIN,
        ST_COMMIT,
        ST_DONE,
        ST_ERR
    } sched_state_e;

    localparam int ACC_W = 24;

    // The widest difference is 0x7FFF - (-0x8000) = 0xFFFF, so the magnitude
    // always fits in 16 unsigned bits once the 17-bit difference is negated.
    function automatic logic [15:0] abs_diff(input q8_8_t a, input q8_8_t b);
        logic [16:0] d;
        logic [16:0] n;
        d = {a[15], a} - {b[15], b};
        n = ~d + 17'd1;
        return d[16] ? n[15:0] : d[15:0];
    endfunction

endpackage

// File: rtl/nn_train_scheduler_done_edge_watch.sv
// done_edge_watch
// Rising-edge detector for a pipeline "done" level plus a watchdog counter.
//   clk, rst  clock, synchronous active-low reset
//   active    high while the scheduler waits on this pipeline
//   done      done level from the pipeline
//   rise      done went 0->1 this cycle
//   expired   this is the last waiting cycle before the TIMEOUT budget runs out
module done_edge_watch #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic done,
    output logic rise,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic          done_q;
    logic [CW-1:0] cnt;

    // done_q tracks the level continuously so a level already high on entry
    // never looks like an edge. The counter sits at zero outside the wait
    // state, which makes it restart on every entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            done_q <= 1'b0;
            cnt    <= '0;
        end else begin
            done_q <= done;
            if (!active)
                cnt <= '0;
            else if (cnt != CW'(TIMEOUT))
                cnt <= cnt + 1'b1;
        end
    end

    assign rise    = done & ~done_q;
    assign expired = active && (cnt >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/nn_train_scheduler.sv
// nn_train_scheduler
// Owns the live CNN parameters and, per sample, runs one forward pass then
// one training step, committing the trained parameters back.
//   clk, rst                         clock, synchronous active-low reset
//   cmd_start / cmd_abort / init_load run control and parameter preload
//   init_*                           preload values for the live parameters
//   smp_valid/smp_ready, smp_*       sample handshake and payload
//   cur_feature, cur_label           held sample for both pipelines
//   kernel, fc_weights, fc_bias      live parameters
//   fwd_start/fwd_done/fwd_output    forward pipeline control and result
//   trn_start/trn_done/trn_*_out     training pipeline control and results
//   busy, run_done, timeout_err      status
//   epoch_idx, sample_idx            progress counters
//   epoch_abs_err                    sum |fwd_output - label| of last epoch
module nn_train_scheduler
    import nn_pkg::*;
#(
    parameter int NUM_SAMPLES = 4,
    parameter int NUM_EPOCHS  = 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_start,
    input  logic                               cmd_abort,
    input  logic                               init_load,
    input  kernel_t                            init_kernel,
    input  fc_w_t                              init_fc_weights,
    input  q8_8_t                              init_fc_bias,
    input  logic                               smp_valid,
    output logic                               smp_ready,
    input  feature_t                           smp_feature,
    input  q8_8_t                              smp_label,
    output feature_t                           cur_feature,
    output q8_8_t                              cur_label,
    output kernel_t                            kernel,
    output fc_w_t                              fc_weights,
    output q8_8_t                              fc_bias,
    output logic                               fwd_start,
    input  logic                               fwd_done,
    input  q8_8_t                              fwd_output,
    output logic                               trn_start,
    input  logic                               trn_done,
    input  kernel_t                            trn_kernel_out,
    input  fc_w_t                              trn_fc_weights_out,
    input  q8_8_t                              trn_fc_bias_out,
    output logic                               busy,
    output logic                               run_done,
    output logic                               timeout_err,
    output logic [$clog2(NUM_EPOCHS+1)-1:0]    epoch_idx,
    output logic [$clog2(NUM_SAMPLES+1)-1:0]   sample_idx,
    output logic [ACC_W-1:0]                   epoch_abs_err
);

    localparam int EW = $clog2(NUM_EPOCHS + 1);
    localparam int SW = $clog2(NUM_SAMPLES + 1);

    sched_state_e     state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;
    logic [15:0]      err;
    logic             fwd_rise, fwd_expired, trn_rise, trn_expired;

    done_edge_watch #(.TIMEOUT(TIMEOUT)) u_fwd_watch (
        .clk     (clk),
        .rst     (rst),
        .active  (state == ST_FWD),
        .done    (fwd_done),
        .rise    (fwd_rise),
        .expired (fwd_expired)
    );

    done_edge_watch #(.TIMEOUT(TIMEOUT)) u_trn_watch (
        .clk     (clk),
        .rst     (rst),
        .active  (state == ST_TRAIN),
        .done    (trn_done),
        .rise    (trn_rise),
        .expired (trn_expired)
    );

    assign err     = abs_diff(fwd_output, cur_label);
    assign acc_sum = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, err};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            smp_ready     <= 1'b0;
            cur_feature   <= '0;
            cur_label     <= '0;
            kernel        <= '0;
            fc_weights    <= '0;
            fc_bias       <= '0;
            fwd_start     <= 1'b0;
            trn_start     <= 1'b0;
            busy          <= 1'b0;
            run_done      <= 1'b0;
            timeout_err   <= 1'b0;
            epoch_idx     <= '0;
            sample_idx    <= '0;
            epoch_abs_err <= '0;
            acc           <= '0;
        end else begin
            fwd_start <= 1'b0;
            trn_start <= 1'b0;
            if (cmd_abort && state != ST_IDLE) begin
                // Abort drops everything in flight; counters, the last epoch
                // metric and the committed parameters survive.
                state       <= ST_IDLE;
                smp_ready   <= 1'b0;
                busy        <= 1'b0;
                run_done    <= 1'b0;
                timeout_err <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (init_load) begin
                            kernel     <= init_kernel;
                            fc_weights <= init_fc_weights;
                            fc_bias    <= init_fc_bias;
                        end
                        if (cmd_start) begin
                            sample_idx <= '0;
                            epoch_idx  <= '0;
                            acc        <= '0;
                            run_done   <= 1'b0;
                            busy       <= 1'b1;
                            smp_ready  <= 1'b1;
                            state      <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (smp_valid && smp_ready) begin
                            cur_feature <= smp_feature;
                            cur_label   <= smp_label;
                            smp_ready   <= 1'b0;
                            fwd_start   <= 1'b1;
                            state       <= ST_FWD;
                        end
                    end
                    ST_FWD: begin
                        // An edge during the fwd_start cycle itself cannot be
                        // the answer to this start, so it is ignored.
                        if (fwd_rise && !fwd_start) begin
                            acc       <= acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
                            trn_start <= 1'b1;
                            state     <= ST_TRAIN;
                        end else if (fwd_expired) begin
                            timeout_err <= 1'b1;
                            busy        <= 1'b0;
                            state       <= ST_ERR;
                        end
                    end
                    ST_TRAIN: begin
                        if (trn_rise) begin
                            state <= ST_COMMIT;
                        end else if (trn_expired) begin
                            timeout_err <= 1'b1;
                            busy        <= 1'b0;
                            state       <= ST_ERR;
                        end
                    end
                    ST_COMMIT: begin
                        kernel     <= trn_kernel_out;
                        fc_weights <= trn_fc_weights_out;
                        fc_bias    <= trn_fc_bias_out;
                        if (sample_idx == SW'(NUM_SAMPLES - 1)) begin
                            epoch_abs_err <= acc;
                            acc           <= '0;
                            sample_idx    <= '0;
                            epoch_idx     <= epoch_idx + 1'b1;
                            if (epoch_idx == EW'(NUM_EPOCHS - 1)) begin
                                busy     <= 1'b0;
                                run_done <= 1'b1;
                                state    <= ST_DONE;
                            end else begin
                                smp_ready <= 1'b1;
                                state     <= ST_FETCH;
                            end
                        end else begin
                            sample_idx <= sample_idx + 1'b1;
                            smp_ready  <= 1'b1;
                            state      <= ST_FETCH;
                        end
                    end
                    ST_DONE: begin
                        // A start here launches the next run directly, exactly
                        // as a start from IDLE would.
                        if (cmd_start) begin
                            sample_idx <= '0;
                            epoch_idx  <= '0;
                            acc        <= '0;
                            run_done   <= 1'b0;
                            busy       <= 1'b1;
                            smp_ready  <= 1'b1;
                            state      <= ST_FETCH;
                        end
                    end
                    ST_ERR: begin
                        state <= ST_ERR;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nn_train_scheduler.sv
// tb_nn_train_scheduler
// Directed bench for nn_train_scheduler. Three instances share every input
// except reset: A (1 sample, 1 epoch, TIMEOUT 16), B (defaults) and C
// (257 samples, 1 epoch, TIMEOUT 16). Only the instance under test is out of
// reset, so the others keep their outputs at zero.
module tb_nn_train_scheduler;
    import nn_pkg::*;

    logic     clk;
    logic     rst_a, rst_b, rst_c;
    logic     cmd_start, cmd_abort, init_load;
    kernel_t  init_kernel;
    fc_w_t    init_fc_weights;
    q8_8_t    init_fc_bias;
    logic     smp_valid;
    feature_t smp_feature;
    q8_8_t    smp_label;
    logic     fwd_done, trn_done;
    q8_8_t    fwd_output;
    kernel_t  trn_kernel_out;
    fc_w_t    trn_fc_weights_out;
    q8_8_t    trn_fc_bias_out;

    logic a_ready, a_fwd_start, a_trn_start, a_busy, a_run_done, a_timeout_err;
    feature_t a_cur_feature;
    q8_8_t a_cur_label, a_fc_bias;
    kernel_t a_kernel;
    fc_w_t a_fc_weights;
    logic [0:0] a_epoch_idx;
    logic [0:0] a_sample_idx;
    logic [23:0] a_epoch_abs_err;

    logic b_ready, b_fwd_start, b_trn_start, b_busy, b_run_done, b_timeout_err;
    feature_t b_cur_feature;
    q8_8_t b_cur_label, b_fc_bias;
    kernel_t b_kernel;
    fc_w_t b_fc_weights;
    logic [3:0] b_epoch_idx;
    logic [2:0] b_sample_idx;
    logic [23:0] b_epoch_abs_err;

    logic c_ready, c_fwd_start, c_trn_start, c_busy, c_run_done, c_timeout_err;
    feature_t c_cur_feature;
    q8_8_t c_cur_label, c_fc_bias;
    kernel_t c_kernel;
    fc_w_t c_fc_weights;
    logic [0:0] c_epoch_idx;
    logic [8:0] c_sample_idx;
    logic [23:0] c_epoch_abs_err;

    logic ready_m, fwd_start_m, trn_start_m;
    int   vectors, miscompares;
    int   hs_cnt, fwd_cnt, trn_cnt;
    int   f0, t0, h0;

    nn_train_scheduler #(.NUM_SAMPLES(1), .NUM_EPOCHS(1), .TIMEOUT(16)) dut_a (
        .clk(clk), .rst(rst_a), .cmd_start(cmd_start), .cmd_abort(cmd_abort), .init_load(init_load),
        .init_kernel(init_kernel), .init_fc_weights(init_fc_weights), .init_fc_bias(init_fc_bias),
        .smp_valid(smp_valid), .smp_ready(a_ready), .smp_feature(smp_feature), .smp_label(smp_label),
        .cur_feature(a_cur_feature), .cur_label(a_cur_label),
        .kernel(a_kernel), .fc_weights(a_fc_weights), .fc_bias(a_fc_bias),
        .fwd_start(a_fwd_start), .fwd_done(fwd_done), .fwd_output(fwd_output),
        .trn_start(a_trn_start), .trn_done(trn_done), .trn_kernel_out(trn_kernel_out),
        .trn_fc_weights_out(trn_fc_weights_out), .trn_fc_bias_out(trn_fc_bias_out),
        .busy(a_busy), .run_done(a_run_done), .timeout_err(a_timeout_err),
        .epoch_idx(a_epoch_idx), .sample_idx(a_sample_idx), .epoch_abs_err(a_epoch_abs_err)
    );

    nn_train_scheduler dut_b (
        .clk(clk), .rst(rst_b), .cmd_start(cmd_start), .cmd_abort(cmd_abort), .init_load(init_load),
        .init_kernel(init_kernel), .init_fc_weights(init_fc_weights), .init_fc_bias(init_fc_bias),
        .smp_valid(smp_valid), .smp_ready(b_ready), .smp_feature(smp_feature), .smp_label(smp_label),
        .cur_feature(b_cur_feature), .cur_label(b_cur_label),
        .kernel(b_kernel), .fc_weights(b_fc_weights), .fc_bias(b_fc_bias),
        .fwd_start(b_fwd_start), .fwd_done(fwd_done), .fwd_output(fwd_output),
        .trn_start(b_trn_start), .trn_done(trn_done), .trn_kernel_out(trn_kernel_out),
        .trn_fc_weights_out(trn_fc_weights_out), .trn_fc_bias_out(trn_fc_bias_out),
        .busy(b_busy), .run_done(b_run_done), .timeout_err(b_timeout_err),
        .epoch_idx(b_epoch_idx), .sample_idx(b_sample_idx), .epoch_abs_err(b_epoch_abs_err)
    );

    nn_train_scheduler #(.NUM_SAMPLES(257), .NUM_EPOCHS(1), .TIMEOUT(16)) dut_c (
        .clk(clk), .rst(rst_c), .cmd_start(cmd_start), .cmd_abort(cmd_abort), .init_load(init_load),
        .init_kernel(init_kernel), .init_fc_weights(init_fc_weights), .init_fc_bias(init_fc_bias),
        .smp_valid(smp_valid), .smp_ready(c_ready), .smp_feature(smp_feature), .smp_label(smp_label),
        .cur_feature(c_cur_feature), .cur_label(c_cur_label),
        .kernel(c_kernel), .fc_weights(c_fc_weights), .fc_bias(c_fc_bias),
        .fwd_start(c_fwd_start), .fwd_done(fwd_done), .fwd_output(fwd_output),
        .trn_start(c_trn_start), .trn_done(trn_done), .trn_kernel_out(trn_kernel_out),
        .trn_fc_weights_out(trn_fc_weights_out), .trn_fc_bias_out(trn_fc_bias_out),
        .busy(c_busy), .run_done(c_run_done), .timeout_err(c_timeout_err),
        .epoch_idx(c_epoch_idx), .sample_idx(c_sample_idx), .epoch_abs_err(c_epoch_abs_err)
    );

    assign ready_m     = a_ready | b_ready | c_ready;
    assign fwd_start_m = a_fwd_start | b_fwd_start | c_fwd_start;
    assign trn_start_m = a_trn_start | b_trn_start | c_trn_start;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running tallies of handshakes and start pulses from whichever instance is live.
    always @(posedge clk) begin
        if (smp_valid && ready_m) hs_cnt <= hs_cnt + 1;
        if (fwd_start_m) fwd_cnt <= fwd_cnt + 1;
        if (trn_start_m) trn_cnt <= trn_cnt + 1;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic kernel_t fillKernel(input q8_8_t v);
        kernel_t k;
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) k[i][j] = v;
        return k;
    endfunction

    function automatic fc_w_t fillFc(input q8_8_t v);
        fc_w_t w;
        for (int i = 0; i < 4; i++) w[i] = v;
        return w;
    endfunction

    function automatic feature_t fillFeature(input q8_8_t v);
        feature_t f;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) f[i][j] = v;
        return f;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offer a sample and return on the negedge after it is accepted.
    task automatic applyStimulus(input feature_t f, input q8_8_t lbl);
        int guard;
        smp_feature = f;
        smp_label   = lbl;
        smp_valid   = 1'b1;
        guard = 0;
        while (!ready_m && guard < 64) begin
            tick();
            guard++;
        end
        checkOutput("smp_ready_seen", ready_m, 1);
        tick();
        smp_valid = 1'b0;
    endtask

    task automatic fwdRespond(input q8_8_t fout);
        tick();
        fwd_output = fout;
        fwd_done   = 1'b1;
        tick();
        fwd_done = 1'b0;
    endtask

    task automatic trnRespond();
        tick();
        trn_done = 1'b1;
        tick();
        trn_done = 1'b0;
    endtask

    task automatic runSample(input feature_t f, input q8_8_t lbl, input q8_8_t fout);
        applyStimulus(f, lbl);
        fwdRespond(fout);
        trnRespond();
        tick();
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        cmd_start = 1'b0; cmd_abort = 1'b0; init_load = 1'b0;
        init_kernel = '0; init_fc_weights = '0; init_fc_bias = '0;
        smp_valid = 1'b0; smp_feature = '0; smp_label = '0;
        fwd_done = 1'b0; trn_done = 1'b0; fwd_output = '0;
        trn_kernel_out = '0; trn_fc_weights_out = '0; trn_fc_bias_out = '0;
        repeat (3) tick();

        // Reset state
        checkOutput("rst_busy", a_busy, 0);
        checkOutput("rst_smp_ready", a_ready, 0);
        checkOutput("rst_kernel", a_kernel, 0);
        checkOutput("rst_abs_err", a_epoch_abs_err, 0);
        checkOutput("rst_run_done", a_run_done, 0);

        // Single sample, single epoch; load and start in the same cycle
        rst_a = 1'b1;
        tick();
        init_kernel = fillKernel(16'sd64);
        init_fc_weights = fillFc(16'sd128);
        init_fc_bias = 16'sd0;
        init_load = 1'b1;
        cmd_start = 1'b1;
        tick();
        init_load = 1'b0;
        cmd_start = 1'b0;
        checkOutput("load_kernel", a_kernel, fillKernel(16'sd64));
        checkOutput("load_fc", a_fc_weights, fillFc(16'sd128));
        checkOutput("fetch_ready", a_ready, 1);
        checkOutput("fetch_busy", a_busy, 1);
        trn_kernel_out = fillKernel(16'sd70);
        trn_fc_weights_out = fillFc(16'sd120);
        trn_fc_bias_out = 16'sd5;
        f0 = fwd_cnt; t0 = trn_cnt;
        applyStimulus(fillFeature(16'sd256), 16'sd512);
        checkOutput("ready_drop", a_ready, 0);
        checkOutput("fwd_start_pulse", a_fwd_start, 1);
        checkOutput("cur_label", a_cur_label, 16'sd512);
        checkOutput("cur_feature", a_cur_feature, fillFeature(16'sd256));
        fwdRespond(16'sd1152);
        checkOutput("trn_start_pulse", a_trn_start, 1);
        trnRespond();
        checkOutput("kernel_hold_commit", a_kernel, fillKernel(16'sd64));
        tick();
        checkOutput("commit_kernel", a_kernel, fillKernel(16'sd70));
        checkOutput("commit_fc", a_fc_weights, fillFc(16'sd120));
        checkOutput("commit_bias", a_fc_bias, 16'sd5);
        checkOutput("t1_abs_err", a_epoch_abs_err, 640);
        checkOutput("t1_run_done", a_run_done, 1);
        checkOutput("t1_busy", a_busy, 0);
        checkOutput("t1_epoch_idx", a_epoch_idx, 1);
        checkOutput("t1_fwd_pulses", fwd_cnt - f0, 1);
        checkOutput("t1_trn_pulses", trn_cnt - t0, 1);

        // Stale fwd_done level must not advance the FSM
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        checkOutput("abort_run_done", a_run_done, 0);
        checkOutput("abort_keeps_err", a_epoch_abs_err, 640);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        fwd_done = 1'b1;
        trn_kernel_out = fillKernel(-16'sd32);
        t0 = trn_cnt;
        applyStimulus(fillFeature(-16'sd128), 16'sd100);
        repeat (5) tick();
        checkOutput("stale_no_trn", trn_cnt - t0, 0);
        checkOutput("stale_busy", a_busy, 1);
        fwd_done = 1'b0;
        tick();
        fwd_output = 16'sd400;
        fwd_done = 1'b1;
        tick();
        fwd_done = 1'b0;
        checkOutput("stale_then_edge", a_trn_start, 1);
        trnRespond();
        tick();
        checkOutput("stale_abs_err", a_epoch_abs_err, 300);
        checkOutput("stale_kernel", a_kernel, fillKernel(-16'sd32));

        // Training watchdog: trn_done never arrives
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        trn_kernel_out = fillKernel(16'sd999);
        applyStimulus(fillFeature(16'sd1), 16'sd2);
        fwdRespond(16'sd0);
        checkOutput("to_trn_start", a_trn_start, 1);
        repeat (15) tick();
        checkOutput("to_not_yet", a_timeout_err, 0);
        checkOutput("to_busy_wait", a_busy, 1);
        tick();
        checkOutput("to_flag", a_timeout_err, 1);
        checkOutput("to_kernel_hold", a_kernel, fillKernel(-16'sd32));
        checkOutput("to_busy_err", a_busy, 0);
        repeat (3) tick();
        checkOutput("to_err_sticky", a_timeout_err, 1);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        checkOutput("to_abort_clear", a_timeout_err, 0);
        checkOutput("to_abort_idle", a_ready, 0);

        // Reset while in TRAIN
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        applyStimulus(fillFeature(16'sd3), 16'sd4);
        fwdRespond(16'sd50);
        checkOutput("mid_in_train", a_trn_start, 1);
        rst_a = 1'b0;
        tick();
        checkOutput("mid_rst_kernel", a_kernel, 0);
        checkOutput("mid_rst_fc", a_fc_weights, 0);
        checkOutput("mid_rst_label", a_cur_label, 0);
        checkOutput("mid_rst_feature", a_cur_feature, 0);
        checkOutput("mid_rst_abs_err", a_epoch_abs_err, 0);
        checkOutput("mid_rst_busy", a_busy, 0);
        checkOutput("mid_rst_trn_start", a_trn_start, 0);

        // Backpressure, then the full default run
        rst_b = 1'b1;
        tick();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        trn_kernel_out = fillKernel(16'sd11);
        trn_fc_weights_out = fillFc(16'sd22);
        trn_fc_bias_out = 16'sd33;
        f0 = fwd_cnt; t0 = trn_cnt; h0 = hs_cnt;
        repeat (20) tick();
        checkOutput("bp_no_fwd", fwd_cnt - f0, 0);
        checkOutput("bp_ready_held", b_ready, 1);
        checkOutput("bp_busy", b_busy, 1);
        for (int s = 0; s < 32; s++) begin
            runSample(fillFeature(q8_8_t'(s)), q8_8_t'(s * 5), q8_8_t'(s * 37 - 300));
            if (s == 3) begin
                checkOutput("full_epoch0_err", b_epoch_abs_err, 1008);
                checkOutput("full_epoch0_idx", b_epoch_idx, 1);
            end
            if (s == 5) checkOutput("full_sample_idx", b_sample_idx, 2);
        end
        checkOutput("full_handshakes", hs_cnt - h0, 32);
        checkOutput("full_fwd_pulses", fwd_cnt - f0, 32);
        checkOutput("full_trn_pulses", trn_cnt - t0, 32);
        checkOutput("full_epoch_idx", b_epoch_idx, 8);
        checkOutput("full_run_done", b_run_done, 1);
        checkOutput("full_last_err", b_epoch_abs_err, 2576);
        checkOutput("full_kernel", b_kernel, fillKernel(16'sd11));

        // Accumulator saturation over 257 worst-case samples
        rst_b = 1'b0;
        rst_c = 1'b1;
        tick();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        for (int s = 0; s < 257; s++)
            runSample(fillFeature(16'sd0), 16'sh8000, 16'sh7FFF);
        checkOutput("sat_abs_err", c_epoch_abs_err, 24'hFFFFFF);
        checkOutput("sat_run_done", c_run_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
